// File: rtl/project_sel_pkg.sv
// rtl/project_sel_pkg.sv - shared widths, FSM states and pad safe-state values for the project selector
package project_sel_pkg;

  // Width of one project's pad bundle.
  localparam int IO_W = 43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Pads are parked with drivers off and input buffers enabled while no project owns them.
  localparam logic [IO_W-1:0] SAFE_CTRL = '0;
  localparam logic [IO_W-1:0] SAFE_IE   = '1;

endpackage

// File: rtl/cfg_sync.sv
// rtl/cfg_sync.sv - two-flop synchronizer with rising-edge detect for one config pin
module cfg_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta;
  logic prev;

  // Two-stage capture of the asynchronous pin plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/project_selector.sv
// rtl/project_selector.sv - serial-configured pad owner routing the pad bundle to one of NPROJ projects
module project_selector
  import project_sel_pkg::*;
#(
  parameter int NPROJ    = 8,
  parameter int SEL_W    = $clog2(NPROJ),
  parameter int RST_HOLD = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_sclk_i,
  input  logic                  cfg_sdat_i,
  input  logic                  cfg_latch_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_oe_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_cs_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_sl_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_pu_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_pd_i,
  input  logic [NPROJ*IO_W-1:0] proj_io_ie_i,
  output logic [NPROJ*IO_W-1:0] proj_io_in_o,
  output logic [NPROJ-1:0]      proj_rst_n_o,
  input  logic [IO_W-1:0]       pad_io_in_i,
  output logic [IO_W-1:0]       pad_io_out_o,
  output logic [IO_W-1:0]       pad_io_oe_o,
  output logic [IO_W-1:0]       pad_io_cs_o,
  output logic [IO_W-1:0]       pad_io_sl_o,
  output logic [IO_W-1:0]       pad_io_pu_o,
  output logic [IO_W-1:0]       pad_io_pd_o,
  output logic [IO_W-1:0]       pad_io_ie_o,
  output logic [SEL_W-1:0]      active_sel_o,
  output logic                  cfg_valid_o,
  output logic                  cfg_err_o
);

  localparam logic [SEL_W:0] NPROJ_W   = (SEL_W+1)'(NPROJ);
  localparam logic [7:0]     HOLD_LAST = 8'(RST_HOLD - 1);

  logic sclk_lvl, sclk_rise;
  logic sdat_lvl, sdat_rise;
  logic latch_lvl, latch_rise;

  state_t           state;
  logic [SEL_W-1:0] shift_q;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       hold_cnt;
  logic             err_q;
  logic [SEL_W:0]   shift_cat;
  logic             latch_ok;
  logic             run;
  logic             unused_sync;

  cfg_sync u_sclk_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (cfg_sclk_i),
    .sync (sclk_lvl),
    .rise (sclk_rise)
  );

  cfg_sync u_sdat_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (cfg_sdat_i),
    .sync (sdat_lvl),
    .rise (sdat_rise)
  );

  cfg_sync u_latch_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (cfg_latch_i),
    .sync (latch_lvl),
    .rise (latch_rise)
  );

  // Concatenation keeps the shift well-formed even when SEL_W is 1.
  assign shift_cat   = {shift_q, sdat_lvl};
  assign latch_ok    = ({1'b0, shift_q} < NPROJ_W);
  assign run         = (state == RUN);
  assign unused_sync = ^{sclk_lvl, latch_lvl, sdat_rise, shift_cat[SEL_W]};

  // Serial index register, MSB first; a latch in the same cycle sees the pre-shift value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else if (sclk_rise) begin
      shift_q <= shift_cat[SEL_W-1:0];
    end
  end

  // Selection FSM: a valid latch always restarts the reset hold; an invalid one only flags an error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      sel_q    <= '0;
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else if (latch_rise && latch_ok) begin
      sel_q    <= shift_q;
      hold_cnt <= '0;
      state    <= HOLD;
    end else begin
      if (latch_rise) begin
        err_q <= 1'b1;
      end
      if (state == HOLD) begin
        if (hold_cnt == HOLD_LAST) begin
          state <= RUN;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

  // Pad mux: only the running project drives the pads; otherwise the pads sit in the safe state.
  always_comb begin
    pad_io_out_o = SAFE_CTRL;
    pad_io_oe_o  = SAFE_CTRL;
    pad_io_cs_o  = SAFE_CTRL;
    pad_io_sl_o  = SAFE_CTRL;
    pad_io_pu_o  = SAFE_CTRL;
    pad_io_pd_o  = SAFE_CTRL;
    pad_io_ie_o  = SAFE_IE;
    for (int p = 0; p < NPROJ; p++) begin
      if (run && sel_q == SEL_W'(p)) begin
        pad_io_out_o = proj_io_out_i[p*IO_W +: IO_W];
        pad_io_oe_o  = proj_io_oe_i[p*IO_W +: IO_W];
        pad_io_cs_o  = proj_io_cs_i[p*IO_W +: IO_W];
        pad_io_sl_o  = proj_io_sl_i[p*IO_W +: IO_W];
        pad_io_pu_o  = proj_io_pu_i[p*IO_W +: IO_W];
        pad_io_pd_o  = proj_io_pd_i[p*IO_W +: IO_W];
        pad_io_ie_o  = proj_io_ie_i[p*IO_W +: IO_W];
      end
    end
  end

  // Per-project gating: unselected projects stay in reset and see zero pad input.
  for (genvar p = 0; p < NPROJ; p++) begin : g_proj
    assign proj_io_in_o[p*IO_W +: IO_W] = (run && sel_q == SEL_W'(p)) ? pad_io_in_i : '0;
    assign proj_rst_n_o[p]              = run && (sel_q == SEL_W'(p));
  end

  assign active_sel_o = sel_q;
  assign cfg_valid_o  = run;
  assign cfg_err_o    = err_q;

endmodule
